// File: rtl/dh_xor_check_seq.sv
// dh_xor_check_seq: end-to-end XOR key checker for a burst of NUM_WORDS words.
// Each accepted word is decrypted with the working key and compared against the
// expected plaintext. The block reports pass/fail, the mismatch count and the
// index of the first failing word. An optional rolling-key mode rotates the
// working key left by one bit after every accepted word.
module dh_xor_check_seq #(
  parameter  int DATA_W    = 32,
  parameter  int KEY_W     = 4,
  parameter  int NUM_WORDS = 8,
  parameter  int KEY_ROT   = 0,
  localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  key_i,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] cipher_i,
  input  logic [DATA_W-1:0] ref_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              err_valid,
  output logic [CNT_W-1:0]  err_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] key_w;
  logic [CNT_W-1:0]  idx;
  logic              busy_d, ready_d, done_d;

  // Shift-based form so the rotate stays legal even for DATA_W == 1.
  function automatic logic [DATA_W-1:0] rot_left1(input logic [DATA_W-1:0] x);
    return (x << 1) | (x >> (DATA_W - 1));
  endfunction

  // A beat is only counted in RUN and only when abort is not asserted with it.
  logic beat, word_mis, last_word, start_acc;
  assign start_acc = (state_q == S_IDLE) && start;
  assign beat      = (state_q == S_RUN) && in_valid && in_ready && !abort;
  assign word_mis  = ((cipher_i ^ key_w) != ref_i);
  assign last_word = (idx == CNT_W'(NUM_WORDS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: abort dominates a simultaneous beat; DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort)                 state_d = S_IDLE;
        else if (beat && last_word) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with it.
  always_comb begin
    busy_d  = (state_d == S_RUN);
    ready_d = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      in_ready <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy     <= busy_d;
      in_ready <= ready_d;
      done     <= done_d;
    end
  end

  // Burst datapath: key latch on start, per-beat compare, counters and verdict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_w        <= '0;
      idx          <= '0;
      mismatch_cnt <= '0;
      err_valid    <= 1'b0;
      err_idx      <= '0;
      pass         <= 1'b0;
    end else if (start_acc) begin
      key_w        <= DATA_W'(key_i);
      idx          <= '0;
      mismatch_cnt <= '0;
      err_valid    <= 1'b0;
      err_idx      <= '0;
      pass         <= 1'b0;
    end else if (beat) begin
      if (word_mis) begin
        mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (!err_valid) begin
          err_valid <= 1'b1;
          err_idx   <= idx;
        end
      end
      idx <= idx + CNT_W'(1);
      if (KEY_ROT != 0) key_w <= rot_left1(key_w);
      // Verdict includes the last word, which is not yet in mismatch_cnt.
      if (last_word) pass <= (mismatch_cnt == '0) && !word_mis;
    end
  end

endmodule
